// File: rtl/duc_coef_loader.sv
// rtl/duc_coef_loader.sv - DUC filter coefficient load sequencer
//
// Purpose: holds a host-written bank of 16-bit filter taps and, on a start
// request, resets the filter's configuration logic and streams the taps into
// it one per cycle. Reports busy/done/error and a 16-bit wraparound checksum.
//
// Ports:
//   i_config_clk      configuration clock (only clock)
//   i_config_rst_n    asynchronous active-low reset
//   i_wr_en/addr/data host tap write (accepted only when idle and in range)
//   i_start           one-cycle load request
//   i_abort           abort an in-progress sequence (RST/SETTLE/LOAD)
//   o_config_rst      filter configuration reset, active high
//   o_load_parameter  filter tap load strobe
//   o_parameter_data  filter tap value (0 when not loading)
//   o_busy            sequence in progress
//   o_done            one-cycle pulse at load completion
//   o_err             one-cycle pulse on rejected write/start or abort
//   o_checksum        sum of taps of the last completed load

module duc_coef_loader #(
    parameter int NUM_COEF   = 32,
    parameter int AW         = 5,
    parameter int RST_CYCLES = 4
) (
    input  logic          i_config_clk,
    input  logic          i_config_rst_n,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [15:0]   i_wr_data,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_config_rst,
    output logic          o_load_parameter,
    output logic [15:0]   o_parameter_data,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [15:0]   o_checksum
);

    // One counter serves both the reset-pulse timer and the tap index; it
    // must be able to hold NUM_COEF itself (end-of-stream marker).
    localparam int CW_A = AW + 1;
    localparam int CW_R = $clog2(RST_CYCLES + 1);
    localparam int CW   = (CW_A > CW_R) ? CW_A : CW_R;
    localparam int IW   = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;

    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] IDX_END  = CW'(NUM_COEF);
    localparam logic [AW:0]   ADDR_LIM = (AW + 1)'(NUM_COEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SETTLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t        r_state;
    logic [15:0]   r_taps [NUM_COEF];
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_acc;

    logic          w_busy;
    logic          w_wr_ok;
    logic          w_wr_bad;
    logic          w_start_bad;
    logic          w_abort;
    logic [IW-1:0] w_wr_idx;
    logic [IW-1:0] w_rd_idx;
    logic [15:0]   w_tap;

    assign w_busy      = (r_state != S_IDLE);
    assign w_wr_ok     = i_wr_en && !w_busy && ({1'b0, i_wr_addr} < ADDR_LIM);
    assign w_wr_bad    = i_wr_en && !w_wr_ok;
    assign w_start_bad = i_start && w_busy;
    assign w_abort     = i_abort && ((r_state == S_RST) || (r_state == S_SETTLE) ||
                                     (r_state == S_LOAD));
    assign w_wr_idx    = i_wr_addr[IW-1:0];
    // Read index is the counter; in SETTLE it is 0, which prefetches tap 0.
    assign w_rd_idx    = r_cnt[IW-1:0];
    assign w_tap       = r_taps[w_rd_idx];

    // Tap bank: cleared by reset, writable only while idle.
    always_ff @(posedge i_config_clk or negedge i_config_rst_n) begin
        if (!i_config_rst_n) begin
            for (int i = 0; i < NUM_COEF; i++) begin
                r_taps[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_taps[w_wr_idx] <= i_wr_data;
        end
    end

    always_ff @(posedge i_config_clk or negedge i_config_rst_n) begin
        if (!i_config_rst_n) begin
            r_state          <= S_IDLE;
            r_cnt            <= '0;
            r_acc            <= '0;
            o_config_rst     <= 1'b0;
            o_load_parameter <= 1'b0;
            o_parameter_data <= '0;
            o_busy           <= 1'b0;
            o_done           <= 1'b0;
            o_err            <= 1'b0;
            o_checksum       <= '0;
        end else begin
            // Coincident offences collapse into one error pulse.
            o_err <= w_wr_bad | w_start_bad | w_abort;

            if (w_abort) begin
                r_state          <= S_IDLE;
                o_config_rst     <= 1'b0;
                o_load_parameter <= 1'b0;
                o_parameter_data <= '0;
                o_busy           <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state      <= S_RST;
                            r_cnt        <= '0;
                            r_acc        <= '0;
                            o_config_rst <= 1'b1;
                            o_busy       <= 1'b1;
                        end
                    end
                    S_RST: begin
                        if (r_cnt == RST_LAST) begin
                            r_state      <= S_SETTLE;
                            r_cnt        <= '0;
                            o_config_rst <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    S_SETTLE: begin
                        r_state          <= S_LOAD;
                        o_load_parameter <= 1'b1;
                        o_parameter_data <= w_tap;
                        r_acc            <= r_acc + w_tap;
                        r_cnt            <= CW'(1);
                    end
                    S_LOAD: begin
                        // r_cnt is the index of the next tap to drive.
                        if (r_cnt == IDX_END) begin
                            r_state          <= S_DONE;
                            o_load_parameter <= 1'b0;
                            o_parameter_data <= '0;
                            o_done           <= 1'b1;
                            o_checksum       <= r_acc;
                        end else begin
                            o_parameter_data <= w_tap;
                            r_acc            <= r_acc + w_tap;
                            r_cnt            <= r_cnt + CW'(1);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        o_done  <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                    default: begin
                        r_state          <= S_IDLE;
                        o_config_rst     <= 1'b0;
                        o_load_parameter <= 1'b0;
                        o_parameter_data <= '0;
                        o_busy           <= 1'b0;
                        o_done           <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_duc_coef_loader.sv
// tb/tb_duc_coef_loader.sv - self-checking bench for duc_coef_loader

module tb_duc_coef_loader;

    localparam int N  = 32;
    localparam int R  = 4;
    localparam int AW = 6;

    logic          clk;
    logic          rst_n;
    logic          i_wr_en;
    logic [AW-1:0] i_wr_addr;
    logic [15:0]   i_wr_data;
    logic          i_start;
    logic          i_abort;
    logic          o_config_rst;
    logic          o_load_parameter;
    logic [15:0]   o_parameter_data;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic [15:0]   o_checksum;

    int            n_checks;
    int            n_errors;
    logic [15:0]   m_taps [N];
    logic [15:0]   exp_ck;

    duc_coef_loader #(
        .NUM_COEF   (N),
        .AW         (AW),
        .RST_CYCLES (R)
    ) dut (
        .i_config_clk     (clk),
        .i_config_rst_n   (rst_n),
        .i_wr_en          (i_wr_en),
        .i_wr_addr        (i_wr_addr),
        .i_wr_data        (i_wr_data),
        .i_start          (i_start),
        .i_abort          (i_abort),
        .o_config_rst     (o_config_rst),
        .o_load_parameter (o_load_parameter),
        .o_parameter_data (o_parameter_data),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_err            (o_err),
        .o_checksum       (o_checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic rst, input logic ld,
                              input logic [15:0] data, input logic done, input logic busy,
                              input logic err, input logic [15:0] ck);
        check({tag, ".rst"},  o_config_rst,     rst);
        check({tag, ".ld"},   o_load_parameter, ld);
        check({tag, ".data"}, o_parameter_data, data);
        check({tag, ".done"}, o_done,           done);
        check({tag, ".busy"}, o_busy,           busy);
        check({tag, ".err"},  o_err,            err);
        check({tag, ".ck"},   o_checksum,       ck);
    endtask

    // Called just after a negedge; returns just after the next negedge.
    task automatic host_write(input logic [AW-1:0] a, input logic [15:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        @(posedge clk);
        #1;
        i_wr_en = 1'b0;
        @(negedge clk);
        check($sformatf("wr_err a=%0d", a), o_err, (int'(a) >= N));
        if (int'(a) < N) m_taps[a] = d;
    endtask

    task automatic clear_inputs();
        i_wr_en   = 1'b0;
        i_wr_addr = '0;
        i_wr_data = '0;
        i_start   = 1'b0;
        i_abort   = 1'b0;
    endtask

    // Reference timeline: cycle j counts from the first cycle after the
    // sampling edge of start. Config reset occupies j<R, gap at j=R, taps at
    // j=R+1..R+N, done at j=R+N+1, idle at j=R+N+2.
    task automatic run_seq(input int abort_at, input int wr_at, input int st_at,
                           input bit noise, input bit abort_with_start);
        logic [15:0] sum;
        logic [15:0] e_data;
        bit          err_next;
        bit          aborted;
        bit          ld;
        sum = '0;
        for (int i = 0; i < N; i++) sum = sum + m_taps[i];
        aborted  = 1'b0;
        i_start  = 1'b1;
        i_abort  = abort_with_start;
        @(posedge clk);
        #1;
        clear_inputs();
        err_next = 1'b0;
        for (int j = 0; j <= R + N + 2; j++) begin
            @(negedge clk);
            if (abort_at >= 0 && abort_at <= R + N && j == abort_at + 1) begin
                check_outs($sformatf("abort j=%0d", j), 0, 0, 16'h0, 0, 0, 1, exp_ck);
                aborted = 1'b1;
                break;
            end
            ld     = (j >= R + 1) && (j <= R + N);
            e_data = ld ? m_taps[j - R - 1] : 16'h0;
            check_outs($sformatf("seq j=%0d", j), (j < R), ld, e_data, (j == R + N + 1),
                       (j <= R + N + 1), err_next, (j >= R + N + 1) ? sum : exp_ck);
            if (j == R + N + 2) break;
            err_next = 1'b0;
            if (j == abort_at) begin
                i_abort = 1'b1;
                if (j <= R + N) err_next = 1'b1;
            end
            if (j == wr_at) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 6'd3;
                i_wr_data = 16'hDEAD;
                err_next  = 1'b1;
            end
            if (j == st_at) begin
                i_start  = 1'b1;
                err_next = 1'b1;
            end
            if (noise && $urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) begin
                    i_wr_en   = 1'b1;
                    i_wr_addr = AW'($urandom_range(0, 63));
                    i_wr_data = 16'($urandom);
                end else begin
                    i_start = 1'b1;
                end
                err_next = 1'b1;
            end
            @(posedge clk);
            #1;
            clear_inputs();
        end
        if (!aborted) exp_ck = sum;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_ck   = '0;
        for (int i = 0; i < N; i++) m_taps[i] = '0;
        clear_inputs();
        rst_n = 1'b0;

        repeat (2) @(negedge clk);
        check_outs("reset", 0, 0, 16'h0, 0, 0, 0, 16'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_outs("post_reset", 0, 0, 16'h0, 0, 0, 0, 16'h0);

        // Abort while idle is ignored.
        i_abort = 1'b1;
        @(posedge clk);
        #1;
        i_abort = 1'b0;
        @(negedge clk);
        check("idle_abort.err", o_err, 1'b0);
        check("idle_abort.busy", o_busy, 1'b0);

        // Normal load with a rejected restart during RST.
        for (int i = 0; i < N; i++) host_write(AW'(i), 16'h0100 + 16'(i));
        host_write(6'd32, 16'h1234);
        run_seq(-1, -1, 1, 1'b0, 1'b0);
        check("normal_ck", o_checksum, 16'h21F0);

        // Write during LOAD rejected; tap[3] intact on the next load.
        run_seq(-1, R + 6, -1, 1'b0, 1'b1);
        check("tap3_ck", o_checksum, 16'h21F0);

        // Checksum wrap.
        for (int i = 0; i < N; i++) host_write(AW'(i), 16'hFFFF);
        run_seq(-1, -1, -1, 1'b0, 1'b0);
        check("wrap_ck", o_checksum, 16'hFFE0);

        // Abort on the 10th LOAD cycle, then a full replay.
        for (int i = 0; i < N; i++) host_write(AW'(i), 16'($urandom));
        run_seq(R + 10, -1, -1, 1'b0, 1'b0);
        check("abort_ck_kept", o_checksum, 16'hFFE0);
        @(negedge clk);
        run_seq(-1, -1, -1, 1'b0, 1'b0);

        // Boundary aborts: first RST cycle, SETTLE, last tap, DONE (ignored).
        run_seq(0, -1, -1, 1'b0, 1'b0);
        run_seq(R, -1, -1, 1'b0, 1'b0);
        run_seq(R + N, -1, -1, 1'b0, 1'b0);
        run_seq(R + N + 1, -1, -1, 1'b0, 1'b0);

        // Back-to-back: second start on the first idle cycle after done.
        run_seq(-1, -1, -1, 1'b0, 1'b0);
        run_seq(-1, -1, -1, 1'b0, 1'b0);

        // Randomized passes with noise and random aborts.
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 2) != 0) host_write(AW'(i), 16'($urandom));
            end
            host_write(AW'($urandom_range(N, 63)), 16'($urandom));
            if ($urandom_range(0, 2) == 0)
                run_seq($urandom_range(0, R + N + 1), -1, -1, 1'b1, 1'($urandom_range(0, 1)));
            else
                run_seq(-1, -1, -1, 1'b1, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of LOAD.
        for (int i = 0; i < N; i++) host_write(AW'(i), 16'h5A00 + 16'(i));
        i_start = 1'b1;
        @(posedge clk);
        #1;
        i_start = 1'b0;
        repeat (R + 6) @(negedge clk);
        check("pre_areset.ld", o_load_parameter, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check_outs("areset", 0, 0, 16'h0, 0, 0, 0, 16'h0);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) m_taps[i] = '0;
        exp_ck = '0;
        @(negedge clk);
        run_seq(-1, -1, -1, 1'b0, 1'b0);
        check("zero_ck", o_checksum, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
